apb4_mem_ws: RTL and testbench
==============================

# apb4_mem_ws

Parametrised APB4 completer memory: word-organised RAM with byte-lane write strobes, a programmable number of wait states signalled through PREADY, and PSLVERR on bad accesses. It sits on the APB bus beside the other peripherals as the general-purpose scratch and test memory. It replaces the fixed zero-wait, full-word APB memory used so far.

## Interface
- ADDR_WIDTH, 12: PADDR width in bits, byte address.
- DATA_WIDTH, 32: bus width. Must be 8, 16, 32 or 64.
- DEPTH, 256: number of DATA_WIDTH words. Must be a power of two, with DEPTH*DATA_WIDTH/8 <= 2**ADDR_WIDTH.
- WAIT_STATES, 0: PREADY-low cycles per transfer, range 0..15.
- PCLK  in  1  clock; all logic on the rising edge.
- PRESET  in  1  reset, synchronous, active-high.
- PADDR  in  ADDR_WIDTH  byte address.
- PSEL  in  1  completer select.
- PENABLE  in  1  access phase.
- PWRITE  in  1  1 = write, 0 = read.
- PWDATA  in  DATA_WIDTH  write data.
- PSTRB  in  DATA_WIDTH/8  write byte-lane enables.
- PRDATA  out  DATA_WIDTH  read data, registered.
- PREADY  out  1  transfer completes this cycle. Decoded from state registers only.
- PSLVERR  out  1  error response, valid only while PREADY=1.

## Operation
- Definitions:
  - LSB = log2(DATA_WIDTH/8).
  - idx = PADDR[ADDR_WIDTH-1:LSB].
  - err = (PADDR[LSB-1:0] != 0) || (idx >= DEPTH). This is the misaligned or out-of-range condition.
- FSM states: IDLE and ACCESS, plus a 4-bit wait counter cnt.
- IDLE:
  - Setup is detected when PSEL=1 and PENABLE=0.
  - On that edge the block: sets state to ACCESS, loads cnt to WAIT_STATES, and registers err into err_q.
  - On a read it also loads PRDATA: 0 if err, otherwise mem[idx].
- ACCESS:
  - PREADY = (cnt==0). cnt decrements each cycle while it is non-zero.
  - Completion edge: PSEL=1, PENABLE=1 and PREADY=1. On this edge:
    - State returns to IDLE.
    - For a write with !err_q, each byte lane i is written from PWDATA when PSTRB[i]=1. Other lanes are unchanged.
- PSLVERR = PREADY && err_q.
  - An errored write modifies nothing.
  - An errored read returns PRDATA=0.
- A write with PSTRB all-zero completes normally with no change and no error.
- PSTRB is ignored on reads.
- If PSEL=0 while in ACCESS (protocol violation), state returns to IDLE next edge with no write.
- Memory contents are not reset.

## Timing
- Reset values: state IDLE, cnt 0, err_q 0, PRDATA 0, PREADY 0, PSLVERR 0.
- PRESET has priority over everything, including a transfer in progress. An interrupted write leaves memory unchanged.
- Latency is 2+WAIT_STATES cycles per transfer:
  - setup cycle, then WAIT_STATES cycles with PREADY=0, then 1 cycle with PREADY=1.
- PRDATA is valid from the first ACCESS cycle and holds until the next read setup edge.
- Back-to-back transfers: the cycle after completion may be a new setup. The write lands on the completion edge, so a read setup in the following cycle returns the new data.
- PREADY and PSLVERR are 0 in IDLE.

## Configuration
- Macro: APB4_MEM_WS_ERR_EN.
- Defined:
  - err is computed as above.
  - PSLVERR is reported and bad accesses are blocked.
- Undefined:
  - err is forced to 0 and PSLVERR is tied 0.
  - Low address bits are ignored.
  - idx is truncated to log2(DEPTH) bits, so out-of-range addresses wrap modulo DEPTH.

## Test plan
- Reset: hold PRESET=1 for 3 cycles with PSEL toggling.
  - Expect PRDATA=0, PREADY=0, PSLVERR=0 and no FSM activity.
- Write then read, WAIT_STATES=0: write 0xDEADBEEF to 0x010 with PSTRB=0xF, then read 0x010.
  - Expect PREADY=1 in each access cycle, PRDATA=0xDEADBEEF, PSLVERR=0.
- Byte strobes: write 0x11223344 to 0x020 with PSTRB=0xF, then write 0xAABBCCDD with PSTRB=0x5.
  - Expect a read of 0x020 to return 0x11BB33DD.
- Wait states, WAIT_STATES=3: run one read.
  - Expect exactly 3 access cycles with PREADY=0, then 1 cycle with PREADY=1 carrying the data, for 5 cycles total.
- Errors with APB4_MEM_WS_ERR_EN, DEPTH=256, 32-bit:
  - A write to 0x400 gives PSLVERR=1 and memory is unchanged.
  - A read from 0x013 gives PSLVERR=1 and PRDATA=0.
  - Without the macro, a write to 0x400 aliases to 0x000.
- Reset mid-transfer, WAIT_STATES=2: assert PRESET during the second wait cycle of a write to 0x030.
  - Expect outputs to return to reset values and 0x030 to keep its old value.

Source files
------------

// File: rtl/apb4_mem_ws.sv
// apb4_mem_ws: APB4 completer scratch memory.
//  - Word-organised RAM, DEPTH words of DATA_WIDTH bits, byte-lane write strobes.
//  - WAIT_STATES cycles of PREADY=0 before every completion (0..15).
//  - Optional bad-access detection (misaligned or out-of-range), enabled by the
//    macro APB4_MEM_WS_ERR_EN. Without it, low address bits are ignored and the
//    word index wraps modulo DEPTH.
// Memory contents are not reset; control state resets synchronously on PRESET.
module apb4_mem_ws #(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES);

`ifdef APB4_MEM_WS_ERR_EN
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((1 << LSB) - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_W    = (ADDR_WIDTH + 1)'(DEPTH);
`endif

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  state_e                  state_q;
  logic [3:0]              cnt_q;
  logic                    err_q;
  logic                    write_q;
  logic [IDX_W-1:0]        idx_q;
  logic [DATA_WIDTH-1:0]   prdata_q;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0]   idx_full_s;
  logic [IDX_W-1:0]        idx_s;
  logic                    err_s;
  logic                    pready_s;
  logic                    wr_en_s;

  // Word index of the current address; the low IDX_W bits address the array.
  assign idx_full_s = PADDR >> LSB;
  assign idx_s      = idx_full_s[IDX_W-1:0];

`ifdef APB4_MEM_WS_ERR_EN
  // Bad access: byte offset inside the word, or word index beyond DEPTH.
  always_comb begin
    err_s = 1'b0;
    if (((PADDR & ALIGN_MASK) != '0) || ({1'b0, idx_full_s} >= DEPTH_W)) begin
      err_s = 1'b1;
    end else begin
      err_s = 1'b0;
    end
  end
`else
  // Without error checking every address is accepted; high bits simply wrap.
  logic unused_addr_s;
  assign unused_addr_s = ^{PADDR, idx_full_s};
  always_comb begin
    err_s = 1'b0;
  end
`endif

  // Ready is a pure decode of the state registers.
  assign pready_s = (state_q == ST_ACCESS) && (cnt_q == 4'd0);

  // A write lands only on a clean completion edge.
  assign wr_en_s  = pready_s && PSEL && PENABLE && write_q && !err_q;

  // Transfer FSM: setup capture, wait countdown, completion or abort.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      err_q    <= 1'b0;
      write_q  <= 1'b0;
      idx_q    <= '0;
      prdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (PSEL && !PENABLE) begin
            state_q <= ST_ACCESS;
            cnt_q   <= CNT_INIT;
            err_q   <= err_s;
            write_q <= PWRITE;
            idx_q   <= idx_s;
            if (!PWRITE) begin
              prdata_q <= err_s ? '0 : mem_q[idx_s];
            end
          end
        end
        ST_ACCESS: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end
          if (!PSEL) begin
            // Requester dropped the transfer: abandon it, nothing is written.
            state_q <= ST_IDLE;
          end else if (PENABLE && (cnt_q == 4'd0)) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= 4'd0;
          err_q   <= 1'b0;
        end
      endcase
    end
  end

  // Byte-lane write into the array; reset blocks an in-flight write.
  always_ff @(posedge PCLK) begin
    if (!PRESET && wr_en_s) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (PSTRB[i]) begin
          mem_q[idx_q][8*i +: 8] <= PWDATA[8*i +: 8];
        end
      end
    end
  end

  assign PRDATA = prdata_q;
  assign PREADY = pready_s;
`ifdef APB4_MEM_WS_ERR_EN
  assign PSLVERR = pready_s && err_q;
`else
  assign PSLVERR = 1'b0;
`endif

endmodule

// File: tb/tb_apb4_mem_ws.sv
// Self-checking bench for apb4_mem_ws. Three instances share one bus:
// index 0 has WAIT_STATES=0, index 1 has 3, index 2 has 2. A word-level
// reference model derived from the addressing/error rules predicts every
// read value, error response and transfer length.
module tb_apb4_mem_ws;

  logic        clk;
  logic        preset;
  logic [11:0] paddr;
  logic [2:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata  [3];
  logic        pready  [3];
  logic        pslverr [3];

  int checks = 0;
  int errors = 0;
  int ws_of [3] = '{0, 3, 2};

  logic [31:0] mm [3][256];
  bit          mv [3][256];

  apb4_mem_ws #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .DEPTH(256), .WAIT_STATES(0)) dut0 (
    .PCLK(clk), .PRESET(preset), .PADDR(paddr), .PSEL(psel[0]), .PENABLE(penable),
    .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb),
    .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]));
  apb4_mem_ws #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .DEPTH(256), .WAIT_STATES(3)) dut1 (
    .PCLK(clk), .PRESET(preset), .PADDR(paddr), .PSEL(psel[1]), .PENABLE(penable),
    .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb),
    .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]));
  apb4_mem_ws #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .DEPTH(256), .WAIT_STATES(2)) dut2 (
    .PCLK(clk), .PRESET(preset), .PADDR(paddr), .PSEL(psel[2]), .PENABLE(penable),
    .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb),
    .PRDATA(prdata[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic bit m_err(input logic [11:0] a);
`ifdef APB4_MEM_WS_ERR_EN
    return ((int'(a) % 4) != 0) || ((int'(a) / 4) >= 256);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int m_idx(input logic [11:0] a);
    return (int'(a) / 4) % 256;
  endfunction

  task automatic m_write(input int d, input logic [11:0] a, input logic [31:0] wd, input logic [3:0] st);
    int i;
    if (!m_err(a)) begin
      i = m_idx(a);
      for (int b = 0; b < 4; b++) if (st[b]) mm[d][i][8*b +: 8] = wd[8*b +: 8];
      if (st == 4'hF) mv[d][i] = 1'b1;
    end
  endtask

  // ---------------- bus driver ----------------
  task automatic xfer(input int d, input bit wr, input logic [11:0] a, input logic [31:0] wd,
                      input logic [3:0] st, output logic [31:0] rd, output logic er,
                      output int cyc, output bit to);
    int guard;
    @(negedge clk);
    psel = 3'b000; psel[d] = 1'b1; penable = 1'b0;
    pwrite = wr; paddr = a; pwdata = wd; pstrb = st;
    cyc = 1; to = 1'b0;
    @(negedge clk);
    penable = 1'b1;
    cyc = 2; guard = 0;
    while (pready[d] !== 1'b1 && guard < 40) begin
      @(negedge clk);
      cyc++; guard++;
    end
    if (guard >= 40) to = 1'b1;
    rd = prdata[d]; er = pslverr[d];
  endtask

  task automatic bus_idle();
    @(negedge clk);
    psel = 3'b000; penable = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    preset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      psel[0] = ~psel[0];
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (prdata[d] !== 32'h0 || pready[d] !== 1'b0 || pslverr[d] !== 1'b0) begin
          errors++;
          $display("FAIL reset_vals dut%0d: prdata=%h pready=%b pslverr=%b, want 0/0/0",
                   d, prdata[d], pready[d], pslverr[d]);
        end
      end
    end
    @(negedge clk);
    preset = 1'b0; psel = 3'b000; penable = 1'b0;
    @(negedge clk);
    checks++;
    if (pready[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: pready=%b want 0", pready[0]);
    end
  endtask

  task automatic test_write_read();
    logic [31:0] rd; logic er; int cyc; bit to;
    xfer(0, 1'b1, 12'h010, 32'hDEADBEEF, 4'hF, rd, er, cyc, to);
    m_write(0, 12'h010, 32'hDEADBEEF, 4'hF);
    checks++;
    if (to || cyc != 2 || er !== 1'b0) begin
      errors++;
      $display("FAIL wr_ws0: timeout=%0d cycles=%0d pslverr=%b want 0/2/0", to, cyc, er);
    end
    xfer(0, 1'b0, 12'h010, 32'h0, 4'h0, rd, er, cyc, to);
    checks++;
    if (to || cyc != 2 || er !== 1'b0 || rd !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL rd_ws0: timeout=%0d cycles=%0d pslverr=%b prdata=%h want 0/2/0/deadbeef",
               to, cyc, er, rd);
    end
    bus_idle();
  endtask

  task automatic test_strobes();
    logic [31:0] rd; logic er; int cyc; bit to;
    xfer(0, 1'b1, 12'h020, 32'h11223344, 4'hF, rd, er, cyc, to);
    m_write(0, 12'h020, 32'h11223344, 4'hF);
    xfer(0, 1'b1, 12'h020, 32'hAABBCCDD, 4'h5, rd, er, cyc, to);
    m_write(0, 12'h020, 32'hAABBCCDD, 4'h5);
    xfer(0, 1'b1, 12'h020, 32'h55555555, 4'h0, rd, er, cyc, to);
    checks++;
    if (to || er !== 1'b0) begin
      errors++;
      $display("FAIL strb_zero: timeout=%0d pslverr=%b want 0/0", to, er);
    end
    xfer(0, 1'b0, 12'h020, 32'h0, 4'h0, rd, er, cyc, to);
    checks++;
    if (rd !== 32'h11BB33DD) begin
      errors++;
      $display("FAIL strobes: prdata=%h want 11bb33dd", rd);
    end
    bus_idle();
  endtask

  task automatic test_wait_states();
    logic [31:0] rd; logic er; int cyc; bit to;
    xfer(1, 1'b1, 12'h044, 32'hA5A5_0F0F, 4'hF, rd, er, cyc, to);
    m_write(1, 12'h044, 32'hA5A5_0F0F, 4'hF);
    checks++;
    if (to || cyc != 5) begin
      errors++;
      $display("FAIL ws3_write_len: timeout=%0d cycles=%0d want 5", to, cyc);
    end
    xfer(1, 1'b0, 12'h044, 32'h0, 4'hF, rd, er, cyc, to);
    checks++;
    if (to || cyc != 5 || rd !== 32'hA5A5_0F0F || er !== 1'b0) begin
      errors++;
      $display("FAIL ws3_read: timeout=%0d cycles=%0d prdata=%h pslverr=%b want 5/a5a50f0f/0",
               to, cyc, rd, er);
    end
    bus_idle();
    checks++;
    if (pready[1] !== 1'b0) begin
      errors++;
      $display("FAIL ws3_idle: pready=%b want 0", pready[1]);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic er; int cyc; bit to;
    for (int d = 0; d < 2; d++) begin
      xfer(d, 1'b1, 12'h040, 32'hCAFEBABE, 4'hF, rd, er, cyc, to);
      m_write(d, 12'h040, 32'hCAFEBABE, 4'hF);
      xfer(d, 1'b0, 12'h040, 32'h0, 4'h0, rd, er, cyc, to);
      checks++;
      if (to || rd !== 32'hCAFEBABE || cyc != 2 + ws_of[d]) begin
        errors++;
        $display("FAIL b2b dut%0d: timeout=%0d prdata=%h cycles=%0d want cafebabe/%0d",
                 d, to, rd, cyc, 2 + ws_of[d]);
      end
    end
    bus_idle();
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int cyc; bit to;
    logic [31:0] exp;
    xfer(0, 1'b1, 12'h000, 32'h12345678, 4'hF, rd, er, cyc, to);
    m_write(0, 12'h000, 32'h12345678, 4'hF);
    xfer(0, 1'b1, 12'h400, 32'h9ABCDEF0, 4'hF, rd, er, cyc, to);
    m_write(0, 12'h400, 32'h9ABCDEF0, 4'hF);
    checks++;
    if (to || er !== m_err(12'h400)) begin
      errors++;
      $display("FAIL err_wr400: timeout=%0d pslverr=%b want %b", to, er, m_err(12'h400));
    end
    xfer(0, 1'b0, 12'h000, 32'h0, 4'h0, rd, er, cyc, to);
    checks++;
    if (rd !== mm[0][0] || er !== 1'b0) begin
      errors++;
      $display("FAIL err_alias000: prdata=%h pslverr=%b want %h/0", rd, er, mm[0][0]);
    end
    xfer(0, 1'b0, 12'h013, 32'h0, 4'hF, rd, er, cyc, to);
    exp = m_err(12'h013) ? 32'h0 : mm[0][m_idx(12'h013)];
    checks++;
    if (to || er !== m_err(12'h013) || rd !== exp) begin
      errors++;
      $display("FAIL err_rd013: timeout=%0d pslverr=%b prdata=%h want %b/%h",
               to, er, rd, m_err(12'h013), exp);
    end
    bus_idle();
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int cyc; bit to;
    xfer(2, 1'b1, 12'h030, 32'h0BADF00D, 4'hF, rd, er, cyc, to);
    m_write(2, 12'h030, 32'h0BADF00D, 4'hF);
    xfer(2, 1'b0, 12'h030, 32'h0, 4'h0, rd, er, cyc, to);
    // Write to 0x030 interrupted during its second wait cycle.
    @(negedge clk);
    psel = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 12'h030;
    pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    checks++;
    if (pready[2] !== 1'b0) begin
      errors++;
      $display("FAIL mid_wait: pready=%b want 0", pready[2]);
    end
    preset = 1'b1;
    @(negedge clk);
    checks++;
    if (prdata[2] !== 32'h0 || pready[2] !== 1'b0 || pslverr[2] !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_vals: prdata=%h pready=%b pslverr=%b want 0/0/0",
               prdata[2], pready[2], pslverr[2]);
    end
    preset = 1'b0; psel = 3'b000; penable = 1'b0;
    // Reset asserted right on a WAIT_STATES=0 completion edge.
    @(negedge clk);
    psel = 3'b001; penable = 1'b0; pwrite = 1'b1; paddr = 12'h010; pwdata = 32'h0; pstrb = 4'hF;
    @(negedge clk);
    penable = 1'b1;
    preset = 1'b1;
    @(negedge clk);
    preset = 1'b0; psel = 3'b000; penable = 1'b0;
    @(negedge clk);
    checks++;
    if (pready[0] !== 1'b0 || prdata[0] !== 32'h0) begin
      errors++;
      $display("FAIL ready_reset_vals: pready=%b prdata=%h want 0/0", pready[0], prdata[0]);
    end
    xfer(2, 1'b0, 12'h030, 32'h0, 4'h0, rd, er, cyc, to);
    checks++;
    if (to || rd !== 32'h0BADF00D) begin
      errors++;
      $display("FAIL mid_mem_kept: timeout=%0d prdata=%h want 0badf00d", to, rd);
    end
    xfer(0, 1'b0, 12'h010, 32'h0, 4'h0, rd, er, cyc, to);
    checks++;
    if (to || rd !== mm[0][4]) begin
      errors++;
      $display("FAIL ready_mem_kept: timeout=%0d prdata=%h want %h", to, rd, mm[0][4]);
    end
    bus_idle();
  endtask

  task automatic test_random();
    logic [31:0] rd; logic er; int cyc; bit to;
    logic [31:0] wd, exp;
    logic [11:0] a;
    logic [3:0]  st;
    int d, r, i;
    bit wr;
    for (int n = 0; n < 120; n++) begin
      d  = int'($urandom_range(0, 2));
      r  = int'($urandom_range(0, 9));
      if (r < 8)       a = 12'h100 + 12'(4 * r);
      else if (r == 8) a = 12'h100 + 12'(4 * $urandom_range(0, 7)) + 12'($urandom_range(1, 3));
      else             a = 12'h400 + 12'(4 * $urandom_range(0, 7));
      wr = $urandom_range(0, 1) == 1;
      wd = $urandom;
      st = (n < 30) ? 4'hF : 4'($urandom_range(0, 15));
      xfer(d, wr, a, wd, st, rd, er, cyc, to);
      checks++;
      if (to || cyc != 2 + ws_of[d] || er !== m_err(a)) begin
        errors++;
        $display("FAIL rnd_resp n=%0d dut%0d addr=%h: timeout=%0d cycles=%0d pslverr=%b want %0d/%b",
                 n, d, a, to, cyc, er, 2 + ws_of[d], m_err(a));
      end
      if (wr) begin
        m_write(d, a, wd, st);
      end else begin
        i = m_idx(a);
        if (m_err(a) || mv[d][i]) begin
          exp = m_err(a) ? 32'h0 : mm[d][i];
          checks++;
          if (rd !== exp) begin
            errors++;
            $display("FAIL rnd_data n=%0d dut%0d addr=%h: prdata=%h want %h", n, d, a, rd, exp);
          end
        end
      end
      if ($urandom_range(0, 3) == 0) bus_idle();
    end
    bus_idle();
  endtask

  initial begin
    preset = 1'b1; psel = 3'b000; penable = 1'b0; pwrite = 1'b0;
    paddr = 12'h0; pwdata = 32'h0; pstrb = 4'h0;
    for (int d = 0; d < 3; d++) for (int k = 0; k < 256; k++) begin
      mm[d][k] = 32'h0; mv[d][k] = 1'b0;
    end
    test_reset();
    test_write_read();
    test_strobes();
    test_wait_states();
    test_back_to_back();
    test_errors();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
